// File: rtl/stepper_pkg.sv
// Shared types and constants for the stepper phase decoder.
// The Gray phase order 00,01,11,10 maps to binary 0,1,2,3, so a forward step is +1 mod 4.
package stepper_pkg;

    typedef logic [1:0] phase_t;

    typedef enum logic {
        DIR_REVERSE = 1'b0,
        DIR_FORWARD = 1'b1
    } dir_e;

    typedef enum logic {
        UNPRIMED = 1'b0,
        TRACKING = 1'b1
    } decoder_state_e;

    localparam phase_t DELTA_FWD  = 2'd1;
    localparam phase_t DELTA_SKIP = 2'd2;
    localparam phase_t DELTA_REV  = 2'd3;

    // Binary view of a candidate phase that has not been captured yet.
    function automatic phase_t gray2bin_f(input phase_t gray);
        return {gray[1], gray[1] ^ gray[0]};
    endfunction

endpackage

// File: rtl/converter_gray2bin.sv
// Combinational Gray-to-binary converter of arbitrary width.
// Each binary bit is the XOR of all Gray bits at or above its position.
module converter_gray2bin #(
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic [DATA_WIDTH-1:0] gray_in,
    output logic [DATA_WIDTH-1:0] bin_c
);

    always_comb begin
        bin_c = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            bin_c[i] = ^(gray_in >> i);
        end
    end

endmodule

// File: rtl/stepper_phase_decoder.sv
// Turns the paper-feed motor's two-phase drive into step pulses, direction and a signed position.
// Phases are synchronised, debounced, then compared against the last accepted phase in binary.
module stepper_phase_decoder
    import stepper_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned COUNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             phase_in,
    input  logic                   position_clear,
    input  logic                   error_clear,
    output logic                   primed,
    output logic [1:0]             phase_bin,
    output logic                   step_pulse,
    output logic                   step_dir,
    output logic [COUNT_WIDTH-1:0] position,
    output logic                   skip_error
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    phase_t                 sync_q [SYNC_STAGES];
    phase_t                 sync_d [SYNC_STAGES];
    phase_t                 synced_c;
    phase_t                 cand_q, cand_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   accept_c;

    decoder_state_e         state_q, state_d;
    phase_t                 stable_q, stable_d;
    phase_t                 bin_old_c, bin_new_c, delta_c;

    logic                   primed_q, primed_d;
    logic                   step_pulse_q, step_pulse_d;
    dir_e                   step_dir_q, step_dir_d;
    logic [COUNT_WIDTH-1:0] position_q, position_d;
    logic                   skip_error_q, skip_error_d;

    // Synchroniser shift chain, one phase pair per stage.
    always_comb begin
        sync_d[0] = phase_in;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign synced_c = sync_q[SYNC_STAGES-1];

    // Run-length debouncer: candidate tracks the synced value, count saturates at the threshold.
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (synced_c != cand_q) begin
            cand_d = synced_c;
            cnt_d  = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Acceptance is judged on the updated count so outputs land on the threshold edge.
    assign accept_c = (cnt_d == CNT_MAX) &&
                      ((cand_d != stable_q) || (state_q == UNPRIMED));

    converter_gray2bin #(
        .DATA_WIDTH (2)
    ) u_gray2bin (
        .gray_in (stable_q),
        .bin_c   (bin_old_c)
    );

    assign bin_new_c = gray2bin_f(cand_d);
    assign delta_c   = bin_new_c - bin_old_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= UNPRIMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UNPRIMED: if (accept_c) state_d = TRACKING;
            TRACKING: state_d = TRACKING;
            default:  state_d = UNPRIMED;
        endcase
    end

    // Step classification; error set beats error clear, position clear beats a step.
    always_comb begin
        stable_d     = stable_q;
        primed_d     = primed_q;
        step_pulse_d = 1'b0;
        step_dir_d   = step_dir_q;
        position_d   = position_q;
        skip_error_d = skip_error_q;

        if (error_clear) begin
            skip_error_d = 1'b0;
        end

        if (accept_c) begin
            stable_d = cand_d;
            case (state_q)
                UNPRIMED: primed_d = 1'b1;
                TRACKING: begin
                    case (delta_c)
                        DELTA_FWD: begin
                            step_pulse_d = 1'b1;
                            step_dir_d   = DIR_FORWARD;
                            position_d   = position_q + COUNT_WIDTH'(1);
                        end
                        DELTA_REV: begin
                            step_pulse_d = 1'b1;
                            step_dir_d   = DIR_REVERSE;
                            position_d   = position_q - COUNT_WIDTH'(1);
                        end
                        DELTA_SKIP: skip_error_d = 1'b1;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end

        if (position_clear) begin
            position_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            cand_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= '0;
            primed_q     <= 1'b0;
            step_pulse_q <= 1'b0;
            step_dir_q   <= DIR_REVERSE;
            position_q   <= '0;
            skip_error_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            primed_q     <= primed_d;
            step_pulse_q <= step_pulse_d;
            step_dir_q   <= step_dir_d;
            position_q   <= position_d;
            skip_error_q <= skip_error_d;
        end
    end

    assign primed     = primed_q;
    assign phase_bin  = bin_old_c;
    assign step_pulse = step_pulse_q;
    assign step_dir   = step_dir_q;
    assign position   = position_q;
    assign skip_error = skip_error_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: directed vector table, corner-case sequences, random stimulus
// against a window-based reference model, and a counter-wrap run on a fast-debounce instance.
module tb_stepper_phase_decoder;

    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, position_clear, error_clear;
    logic [1:0]  phase_in;
    logic        primed, step_pulse, step_dir, skip_error;
    logic [1:0]  phase_bin;
    logic [15:0] position;

    logic        f_rst_n, f_pclr, f_eclr;
    logic [1:0]  f_phase;
    logic        f_primed, f_pulse, f_dir, f_skip;
    logic [1:0]  f_bin;
    logic [15:0] f_pos;

    stepper_phase_decoder #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .COUNT_WIDTH(16)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .phase_in(phase_in),
        .position_clear(position_clear), .error_clear(error_clear),
        .primed(primed), .phase_bin(phase_bin), .step_pulse(step_pulse),
        .step_dir(step_dir), .position(position), .skip_error(skip_error)
    );

    stepper_phase_decoder #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .COUNT_WIDTH(16)
    ) u_fast (
        .clk(clk), .rst_n(f_rst_n), .phase_in(f_phase),
        .position_clear(f_pclr), .error_clear(f_eclr),
        .primed(f_primed), .phase_bin(f_bin), .step_pulse(f_pulse),
        .step_dir(f_dir), .position(f_pos), .skip_error(f_skip)
    );

    int n_vec = 0;
    int n_bad = 0;
    int pulse_cnt = 0;

    // Reference model state.
    logic [1:0]  m_sync[$];
    logic [1:0]  m_hist[$];
    bit          m_primed, m_pulse, m_dir, m_skip;
    logic [1:0]  m_stable;
    logic [15:0] m_pos;

    function automatic logic [1:0] g_of(input int i);
        case (i % 4)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    function automatic int idx_of(input logic [1:0] g);
        for (int i = 0; i < 4; i++) if (g_of(i) == g) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge of the specified behaviour, using the inputs present at that edge.
    task automatic model_edge();
        logic [1:0] seen;
        bit         same, acc;
        int         delta;
        if (!rst_n) begin
            m_sync.delete();
            for (int i = 0; i < S; i++) m_sync.push_back(2'b00);
            m_hist.delete();
            m_primed = 0; m_stable = 2'b00; m_pulse = 0; m_dir = 0; m_pos = 16'h0; m_skip = 0;
        end else begin
            seen = m_sync.pop_front();
            m_sync.push_back(phase_in);
            m_hist.push_back(seen);
            if (m_hist.size() > D) void'(m_hist.pop_front());
            same = 1;
            foreach (m_hist[i]) if (m_hist[i] != seen) same = 0;
            acc = (m_hist.size() == D) && same && ((seen != m_stable) || !m_primed);
            m_pulse = 0;
            if (error_clear) m_skip = 0;
            if (acc) begin
                if (!m_primed) begin
                    m_primed = 1;
                end else begin
                    delta = (idx_of(seen) - idx_of(m_stable) + 4) % 4;
                    if (delta == 1) begin m_pulse = 1; m_dir = 1; m_pos = m_pos + 16'd1; end
                    else if (delta == 3) begin m_pulse = 1; m_dir = 0; m_pos = m_pos - 16'd1; end
                    else if (delta == 2) m_skip = 1;
                end
                m_stable = seen;
            end
            if (position_clear) m_pos = 16'h0;
        end
    endtask

    task automatic tick();
        logic [21:0] exp_v, act_v;
        logic [1:0]  b;
        model_edge();
        @(posedge clk);
        #1;
        if (step_pulse === 1'b1) pulse_cnt++;
        b     = 2'(idx_of(m_stable));
        exp_v = {m_primed, b, m_pulse, m_dir, m_pos, m_skip};
        act_v = {primed, phase_bin, step_pulse, step_dir, position, skip_error};
        chk("model", 32'(act_v), 32'(exp_v));
    endtask

    typedef struct {
        logic [1:0]  ph;
        int          hold;
        bit          pclr;
        bit          eclr;
        int          e_pulses;
        bit          e_dir;
        logic [15:0] e_pos;
        bit          e_skip;
        logic [1:0]  e_bin;
    } vec_t;

    vec_t tbl[$];

    initial begin
        rst_n = 1'b0; phase_in = 2'b00; position_clear = 1'b0; error_clear = 1'b0;
        f_rst_n = 1'b0; f_phase = 2'b00; f_pclr = 1'b0; f_eclr = 1'b0;

        tbl.push_back('{2'b01, 10, 0, 0, 1, 1, 16'h0001, 0, 2'd1});
        tbl.push_back('{2'b11, 10, 0, 0, 1, 1, 16'h0002, 0, 2'd2});
        tbl.push_back('{2'b10, 10, 0, 0, 1, 1, 16'h0003, 0, 2'd3});
        tbl.push_back('{2'b00, 10, 0, 0, 1, 1, 16'h0004, 0, 2'd0});
        tbl.push_back('{2'b00, 10, 1, 0, 0, 1, 16'h0000, 0, 2'd0});
        tbl.push_back('{2'b10, 10, 0, 0, 1, 0, 16'hFFFF, 0, 2'd3});
        tbl.push_back('{2'b11, 10, 0, 0, 1, 0, 16'hFFFE, 0, 2'd2});
        tbl.push_back('{2'b01,  3, 0, 0, 0, 0, 16'hFFFE, 0, 2'd2});
        tbl.push_back('{2'b11, 10, 0, 0, 0, 0, 16'hFFFE, 0, 2'd2});
        tbl.push_back('{2'b00, 10, 0, 0, 0, 0, 16'hFFFE, 1, 2'd0});
        tbl.push_back('{2'b00, 10, 0, 1, 0, 0, 16'hFFFE, 0, 2'd0});
        tbl.push_back('{2'b11, 10, 0, 0, 0, 0, 16'hFFFE, 1, 2'd2});
        tbl.push_back('{2'b11, 10, 0, 1, 0, 0, 16'hFFFE, 0, 2'd2});

        // Reset and priming on a held 00.
        tick(); tick();
        chk("reset_primed", 32'(primed), 0);
        chk("reset_position", 32'(position), 0);
        chk("reset_pulse", 32'(step_pulse), 0);
        rst_n = 1'b1;
        pulse_cnt = 0;
        repeat (6) tick();
        chk("prime_primed", 32'(primed), 1);
        chk("prime_bin", 32'(phase_bin), 0);
        chk("prime_no_pulse", 32'(pulse_cnt), 0);

        foreach (tbl[v]) begin
            phase_in = tbl[v].ph;
            position_clear = tbl[v].pclr;
            error_clear = tbl[v].eclr;
            pulse_cnt = 0;
            for (int h = 0; h < tbl[v].hold; h++) begin
                tick();
                position_clear = 1'b0;
                error_clear = 1'b0;
            end
            chk($sformatf("vec%0d_pulses", v), 32'(pulse_cnt), 32'(tbl[v].e_pulses));
            chk($sformatf("vec%0d_dir", v), 32'(step_dir), 32'(tbl[v].e_dir));
            chk($sformatf("vec%0d_pos", v), 32'(position), 32'(tbl[v].e_pos));
            chk($sformatf("vec%0d_skip", v), 32'(skip_error), 32'(tbl[v].e_skip));
            chk($sformatf("vec%0d_bin", v), 32'(phase_bin), 32'(tbl[v].e_bin));
        end

        // Skip landing on the same edge as error_clear keeps the flag set.
        phase_in = 2'b00;
        repeat (5) tick();
        chk("skip_latency", 32'(skip_error), 0);
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("skip_set_wins", 32'(skip_error), 1);
        repeat (4) tick();
        error_clear = 1'b1;
        tick();
        error_clear = 1'b0;
        chk("skip_cleared", 32'(skip_error), 0);

        // Forward step with coincident position_clear; also checks 6-edge latency.
        phase_in = 2'b01;
        repeat (5) tick();
        chk("step_latency", 32'(step_pulse), 0);
        position_clear = 1'b1;
        tick();
        position_clear = 1'b0;
        chk("clr_pulse", 32'(step_pulse), 1);
        chk("clr_dir", 32'(step_dir), 1);
        chk("clr_position", 32'(position), 0);
        tick();
        chk("pulse_one_cycle", 32'(step_pulse), 0);

        // Ten forward steps, then reset in the middle of a debounce.
        for (int k = 1; k <= 10; k++) begin
            phase_in = g_of(1 + k);
            repeat (6) tick();
        end
        chk("ten_steps_pos", 32'(position), 10);
        phase_in = g_of(13);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midreset_outputs",
            32'({primed, phase_bin, step_pulse, step_dir, position, skip_error}), 0);
        pulse_cnt = 0;
        repeat (10) tick();
        chk("reprime_primed", 32'(primed), 1);
        chk("reprime_bin", 32'(phase_bin), 1);
        chk("reprime_no_pulse", 32'(pulse_cnt), 0);
        chk("reprime_pos", 32'(position), 0);

        // Random stimulus checked every edge by the model.
        for (int seg = 0; seg < 400; seg++) begin
            int hold;
            phase_in = 2'($urandom_range(0, 3));
            hold = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                position_clear = ($urandom_range(0, 15) == 0);
                error_clear    = ($urandom_range(0, 15) == 0);
                rst_n          = ($urandom_range(0, 299) != 0);
                tick();
            end
        end
        rst_n = 1'b1; position_clear = 1'b0; error_clear = 1'b0;

        // Counter wrap on the single-sample-debounce instance: one step per cycle.
        @(posedge clk); #1;
        f_rst_n = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("fast_primed", 32'(f_primed), 1);
        for (int i = 1; i <= 32767; i++) begin
            f_phase = g_of(i);
            @(posedge clk); #1;
        end
        repeat (4) begin @(posedge clk); #1; end
        chk("wrap_max_pos", 32'(f_pos), 32'h7FFF);
        chk("wrap_dir_fwd", 32'(f_dir), 1);
        f_phase = g_of(32768);
        repeat (4) begin @(posedge clk); #1; end
        chk("wrap_to_min", 32'(f_pos), 32'h8000);
        f_phase = g_of(32767);
        repeat (4) begin @(posedge clk); #1; end
        chk("wrap_to_max", 32'(f_pos), 32'h7FFF);
        chk("wrap_dir_rev", 32'(f_dir), 0);
        chk("wrap_bin", 32'(f_bin), 3);
        chk("wrap_no_skip", 32'(f_skip), 0);
        chk("wrap_pulse_idle", 32'(f_pulse), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
